// File: rtl/lmsm_pkg.sv
// Shared constants for the LM/SM register sequencer: FSM state codes,
// register-file geometry and a small mask helper.
package lmsm_pkg;

  // Register file geometry
  localparam int REG_IDX_W = 3;
  localparam int NUM_REGS  = 8;

  // FSM state encoding (2-bit binary)
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACTIVE = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  // True when the mask holds at most one set bit: (m & (m-1)) == 0
  function automatic logic at_most_one_bit(input logic [NUM_REGS-1:0] m);
    logic [NUM_REGS-1:0] m_minus_one;
    m_minus_one = m - {{(NUM_REGS-1){1'b0}}, 1'b1};
    return ((m & m_minus_one) == {NUM_REGS{1'b0}});
  endfunction

  // One-hot decode of a register index, used to clear a serviced bit
  function automatic logic [NUM_REGS-1:0] idx_onehot(input logic [REG_IDX_W-1:0] idx);
    logic [NUM_REGS-1:0] oh;
    oh = {{(NUM_REGS-1){1'b0}}, 1'b1} << idx;
    return oh;
  endfunction

endpackage

// File: rtl/lmsm_reg_sequencer_prienc8_lsb.sv
// 8-bit LSB-first priority encoder: index of the lowest set bit plus a
// 'none' flag. Index is forced to zero when no bit is set.
module prienc8_lsb
  import lmsm_pkg::*;
(
  input  logic [NUM_REGS-1:0]  mask_i,
  output logic [REG_IDX_W-1:0] idx_o,
  output logic                 none_o
);

  // Scan from the top down so the last hit is the lowest set bit
  always_comb begin
    idx_o  = {REG_IDX_W{1'b0}};
    none_o = 1'b1;
    for (int i = NUM_REGS - 1; i >= 0; i--) begin
      if (mask_i[i]) begin
        idx_o  = REG_IDX_W'(i);
        none_o = 1'b0;
      end else begin
        idx_o  = idx_o;
        none_o = none_o;
      end
    end
  end

endmodule

// File: rtl/lmsm_reg_sequencer.sv
// LM/SM register sequencer. Latches a register mask and base address on
// start, then presents one (register index, memory address) transfer per
// step, lowest register first, and pulses done when the list is drained.
// All outputs are decoded from registered state only.
module lmsm_reg_sequencer
  import lmsm_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int ADDR_STEP = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [NUM_REGS-1:0]  reg_list,
  input  logic [ADDR_W-1:0]    base_addr,
  input  logic                 step,
  output logic                 busy,
  output logic                 valid,
  output logic [REG_IDX_W-1:0] reg_idx,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic                 last,
  output logic                 done
);

  logic [1:0]           state_q, state_d;
  logic [NUM_REGS-1:0]  mask_q, mask_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;

  logic [REG_IDX_W-1:0] cur_idx_s;
  logic                 mask_empty_s;
  logic [NUM_REGS-1:0]  mask_cleared_s;
  logic                 in_active_s;

  prienc8_lsb u_prienc (
    .mask_i (mask_q),
    .idx_o  (cur_idx_s),
    .none_o (mask_empty_s)
  );

  assign in_active_s    = (state_q == S_ACTIVE);
  assign mask_cleared_s = mask_q & ~idx_onehot(cur_idx_s);

  // Next-state, mask and address update
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    addr_d  = addr_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mask_d = reg_list;
          addr_d = base_addr;
          if (reg_list != {NUM_REGS{1'b0}}) begin
            state_d = S_ACTIVE;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACTIVE: begin
        // Guard on a non-empty mask keeps a corrupted state from sticking here
        if (mask_empty_s) begin
          state_d = S_DONE;
        end else if (step) begin
          mask_d = mask_cleared_s;
          addr_d = addr_q + ADDR_W'(ADDR_STEP);
          if (mask_cleared_s == {NUM_REGS{1'b0}}) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ACTIVE;
          end
        end else begin
          state_d = S_ACTIVE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        mask_d  = {NUM_REGS{1'b0}};
        addr_d  = {ADDR_W{1'b0}};
      end
    endcase
  end

  // State, mask and address registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      mask_q  <= {NUM_REGS{1'b0}};
      addr_q  <= {ADDR_W{1'b0}};
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      addr_q  <= addr_d;
    end
  end

  // Output decode from registered state; transfer fields are zero unless valid
  always_comb begin
    busy     = (state_q == S_ACTIVE) || (state_q == S_DONE);
    valid    = in_active_s;
    done     = (state_q == S_DONE);
    if (in_active_s) begin
      reg_idx  = cur_idx_s;
      mem_addr = addr_q;
      last     = !mask_empty_s && at_most_one_bit(mask_q);
    end else begin
      reg_idx  = {REG_IDX_W{1'b0}};
      mem_addr = {ADDR_W{1'b0}};
      last     = 1'b0;
    end
  end

endmodule

// File: tb/tb_lmsm_reg_sequencer.sv
// Self-checking bench for lmsm_reg_sequencer: directed scenarios followed by
// random stimulus, all compared against a transfer-queue reference model.
module tb_lmsm_reg_sequencer;

  typedef struct packed {
    logic [2:0]  idx;
    logic [15:0] addr;
  } xfer_t;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  reg_list;
  logic [15:0] base_addr;
  logic        step;
  logic        busy;
  logic        valid;
  logic [2:0]  reg_idx;
  logic [15:0] mem_addr;
  logic        last;
  logic        done;

  int n_cmp;
  int n_err;

  // Reference model: pending transfers and a pending done pulse
  xfer_t mdl_q[$];
  logic  mdl_done;

  // Transfers observed on the DUT (valid cycles), for directed sequence checks
  xfer_t obs_q[$];

  lmsm_reg_sequencer #(.ADDR_W(16), .ADDR_STEP(1)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .reg_list  (reg_list),
    .base_addr (base_addr),
    .step      (step),
    .busy      (busy),
    .valid     (valid),
    .reg_idx   (reg_idx),
    .mem_addr  (mem_addr),
    .last      (last),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic        e_valid;
    logic [2:0]  e_idx;
    logic [15:0] e_addr;
    e_valid = (mdl_q.size() != 0);
    e_idx   = e_valid ? mdl_q[0].idx  : 3'd0;
    e_addr  = e_valid ? mdl_q[0].addr : 16'd0;
    chk("busy",     {31'd0, busy},     {31'd0, (e_valid || mdl_done)});
    chk("valid",    {31'd0, valid},    {31'd0, e_valid});
    chk("reg_idx",  {29'd0, reg_idx},  {29'd0, e_idx});
    chk("mem_addr", {16'd0, mem_addr}, {16'd0, e_addr});
    chk("last",     {31'd0, last},     {31'd0, (mdl_q.size() == 1)});
    chk("done",     {31'd0, done},     {31'd0, mdl_done});
    if (valid === 1'b1) obs_q.push_back({reg_idx, mem_addr});
  endtask

  // Advance the model by one clock using the inputs just driven
  task automatic model_step();
    xfer_t x;
    logic [15:0] a;
    if (reset) begin
      mdl_q.delete();
      mdl_done = 1'b0;
    end else if (mdl_done) begin
      mdl_done = 1'b0;
    end else if (mdl_q.size() != 0) begin
      if (step) begin
        void'(mdl_q.pop_front());
        if (mdl_q.size() == 0) mdl_done = 1'b1;
      end
    end else if (start) begin
      a = base_addr;
      for (int i = 0; i < 8; i++) begin
        if (reg_list[i]) begin
          x.idx  = i[2:0];
          x.addr = a;
          mdl_q.push_back(x);
          a = a + 16'd1;
        end
      end
      if (mdl_q.size() == 0) mdl_done = 1'b1;
    end
  endtask

  // One clock: check outputs at negedge, drive new inputs, update model
  task automatic cyc(input logic rst, input logic st, input logic [7:0] rl,
                     input logic [15:0] ba, input logic stp);
    @(negedge clk);
    check_outputs();
    reset     = rst;
    start     = st;
    reg_list  = rl;
    base_addr = ba;
    step      = stp;
    model_step();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    mdl_done = 1'b0;
    reset = 1'b1; start = 1'b0; reg_list = 8'd0; base_addr = 16'd0; step = 1'b0;
    repeat (2) @(posedge clk);
    // model is already in reset state; first checked cycle verifies reset outputs
    cyc(1'b0, 1'b0, 8'h00, 16'h0000, 1'b0);

    // 1. 0xA5 from 0x0010 with step held high
    obs_q.delete();
    cyc(1'b0, 1'b1, 8'hA5, 16'h0010, 1'b1);
    repeat (6) cyc(1'b0, 1'b0, 8'h00, 16'h0000, 1'b1);
    chk("t1_count", obs_q.size(), 32'd4);
    if (obs_q.size() == 4) begin
      chk("t1_x0", {13'd0, obs_q[0]}, {13'd0, 3'd0, 16'h0010});
      chk("t1_x1", {13'd0, obs_q[1]}, {13'd0, 3'd2, 16'h0011});
      chk("t1_x2", {13'd0, obs_q[2]}, {13'd0, 3'd5, 16'h0012});
      chk("t1_x3", {13'd0, obs_q[3]}, {13'd0, 3'd7, 16'h0013});
    end

    // 2. empty list: done next cycle, never valid
    obs_q.delete();
    cyc(1'b0, 1'b1, 8'h00, 16'h1234, 1'b1);
    repeat (3) cyc(1'b0, 1'b0, 8'h00, 16'h0000, 1'b1);
    chk("t2_no_valid", obs_q.size(), 32'd0);

    // 3. single register 7 at 0xFFFF
    obs_q.delete();
    cyc(1'b0, 1'b1, 8'h80, 16'hFFFF, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 16'h0000, 1'b1);
    repeat (3) cyc(1'b0, 1'b0, 8'h00, 16'h0000, 1'b0);
    chk("t3_x0", {13'd0, obs_q[0]}, {13'd0, 3'd7, 16'hFFFF});

    // 4. 0x0F with step stalled 3 cycles on idx 1
    cyc(1'b0, 1'b1, 8'h0F, 16'h0100, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 16'h0000, 1'b1);
    repeat (3) cyc(1'b0, 1'b0, 8'h00, 16'h0000, 1'b0);
    repeat (5) cyc(1'b0, 1'b0, 8'h00, 16'h0000, 1'b1);

    // 5. start during ACTIVE is ignored, also with step and start together
    cyc(1'b0, 1'b1, 8'h03, 16'h0200, 1'b0);
    cyc(1'b0, 1'b1, 8'hFF, 16'h0F00, 1'b0);
    cyc(1'b0, 1'b1, 8'hFF, 16'h0F00, 1'b1);
    repeat (4) cyc(1'b0, 1'b0, 8'h00, 16'h0000, 1'b1);
    cyc(1'b0, 1'b1, 8'h02, 16'h0300, 1'b1);  // start+step in IDLE: start wins
    repeat (4) cyc(1'b0, 1'b0, 8'h00, 16'h0000, 1'b1);

    // 6. reset at idx 2 of 0xFF, then a fresh sequence
    cyc(1'b0, 1'b1, 8'hFF, 16'h0400, 1'b0);
    repeat (2) cyc(1'b0, 1'b0, 8'h00, 16'h0000, 1'b1);
    cyc(1'b1, 1'b0, 8'h00, 16'h0000, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 16'h0000, 1'b0);
    chk("t6_idle_after_reset", {31'd0, busy}, 32'd0);
    cyc(1'b0, 1'b1, 8'h30, 16'h0500, 1'b1);
    repeat (4) cyc(1'b0, 1'b0, 8'h00, 16'h0000, 1'b1);

    // Random stimulus
    for (int n = 0; n < 600; n++) begin
      logic [7:0]  rl;
      logic [15:0] ba;
      case ($urandom_range(0, 7))
        0:       rl = 8'h00;
        1:       rl = 8'hFF;
        default: rl = 8'($urandom);
      endcase
      ba = ($urandom_range(0, 3) == 0) ? 16'hFFFC : 16'($urandom);
      cyc(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) == 0), rl, ba,
          ($urandom_range(0, 1) == 1));
    end
    cyc(1'b0, 1'b0, 8'h00, 16'h0000, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
